pc_fetch_sequencer: RTL and testbench
=====================================

// Module: pc_fetch_sequencer
// PURPOSE
//  Fetch controller that owns the program counter and sequences instruction-memory reads.
//  Issues a req/ack fetch per PC, presents the fetched word to decode with a valid/stall hold,
//  applies branch/jump redirects, and wraps the PC to RESET_VEC past PC_LIMIT.
//  Sits between the PC register path and the imem port at the front of the core.
// PARAMETERS
//  RESET_VEC  32'h0000_0000  PC after reset, after i_Start and on wrap
//  PC_LIMIT   32'd8188       highest legal fetch address; any next PC above it becomes RESET_VEC
//  TRAP_VEC   32'h0000_0100  redirect address for a misaligned target (PC_MISALIGN_TRAP_EN only)
// PORTS
//  i_Clk          in   1   clock, rising edge
//  i_Rst_n        in   1   asynchronous reset, active low
//  i_Start        in   1   leave IDLE and begin fetching at RESET_VEC; ignored outside IDLE
//  i_Stall        in   1   decode not ready; hold the presented instruction
//  i_Redirect     in   1   branch/jump taken; 1-cycle pulse
//  iv_Target      in   32  redirect address, sampled when i_Redirect=1
//  o_Imem_Req     out  1   fetch request
//  ov_Imem_Addr   out  32  fetch address; stable while o_Imem_Req=1
//  i_Imem_Ack     in   1   imem returns data this cycle
//  iv_Imem_Data   in   32  instruction word, valid with i_Imem_Ack
//  o_Instr_Valid  out  1   ov_Instr/ov_Instr_Pc valid for decode
//  ov_Instr       out  32  fetched instruction
//  ov_Instr_Pc    out  32  address of ov_Instr
//  o_Trap         out  1   1-cycle misaligned-target pulse; constant 0 without the macro
// BEHAVIOUR
//  Reset (async, any state): state=IDLE, pc=RESET_VEC, every output 0.
//  FSM states: IDLE, FETCH, DRAIN, HOLD.
//  - IDLE: no request. On i_Start: pc=RESET_VEC, go to FETCH.
//  - FETCH: o_Imem_Req=1, ov_Imem_Addr=pc.
//      On ack without redirect: register data and pc into ov_Instr and ov_Instr_Pc.
//      Then assert o_Instr_Valid and go to HOLD.
//      On ack with redirect in the same cycle: drop the data, pc=target, stay in FETCH.
//      On redirect without ack: store target as pending and go to DRAIN.
//  - DRAIN: keep req=1 with the old address until ack; a later redirect overwrites pending.
//      On ack: drop the data, pc=pending, go to FETCH.
//  - HOLD: o_Instr_Valid=1, no request, outputs stable.
//      On redirect: valid=0, pc=target, go to FETCH.
//      Else if !i_Stall: the word is consumed, valid=0, pc=pc+4, go to FETCH.
//      Else stay in HOLD.
//  Priority: redirect > stall > sequential. Minimum cadence is one instruction every 2 cycles.
//  Latency: FETCH with immediate ack gives o_Instr_Valid on the next cycle.
//  Handshake: once req is raised it stays high with the same address until ack. Never abandoned.
//  Next-PC: pc+4 (32-bit, wraps modulo 2^32).
//    Any next PC or target > PC_LIMIT becomes RESET_VEC (unsigned compare).
//  Misalignment (target[1:0]!=0) is handled per CONFIGURATION.
// CONFIGURATION
//  PC_MISALIGN_TRAP_EN defined: a misaligned redirect pulses o_Trap for 1 cycle (cycle after the redirect).
//    The redirect address used is TRAP_VEC instead of the target.
//  PC_MISALIGN_TRAP_EN undefined: target[1:0] is forced to 2'b00; o_Trap is tied 0.
// STRUCTURE
//  Shared package pc_seq_pkg: state encoding (IDLE/FETCH/DRAIN/HOLD, 2-bit), WORD_BYTES=4,
//    and the alignment mask constant.
//  Sub-module pc_next_calc: combinational next-PC mux.
//    Inputs: redirect/target, pc, limit.
//    Functions: +4, limit wrap, align/trap decision.
//  The FSM and registers stay in the top.
// TESTING
//  1 Release reset, pulse i_Start, ack tied 1, no stall:
//    Imem addrs 0,4,8,...; valid on alternate cycles; ov_Instr_Pc=0,4,8.
//  2 Stall 3 cycles in HOLD: o_Instr_Valid stays 1, ov_Instr/ov_Instr_Pc unchanged, o_Imem_Req=0.
//  3 Redirect to 0x40 in FETCH with ack delayed 2 cycles: state enters DRAIN, req held at the old address.
//    The old data is never valid; the next request is to 0x40.
//  4 Consume the word at 8188:
//    The next request is to 0x0. A redirect to 0x3000 also gives a request to 0x0.
//  5 Redirect to 0x42:
//    With the macro: o_Trap=1 for 1 cycle and the next request is to 0x100.
//    Without the macro: the next request is to 0x40 and o_Trap=0.
//  6 Assert i_Rst_n=0 mid-DRAIN: all outputs 0 immediately and state=IDLE.
//    After release, no request until i_Start.

Source files
------------

// File: rtl/pc_seq_pkg.sv
// Shared definitions for the PC fetch sequencer: FSM encoding, word size and
// alignment helpers.
package pc_seq_pkg;

  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_FETCH = 2'd1,
    ST_DRAIN = 2'd2,
    ST_HOLD  = 2'd3
  } state_e;

  localparam logic [31:0] WORD_BYTES = 32'd4;
  localparam logic [31:0] ALIGN_MASK = 32'hFFFF_FFFC;

  function automatic logic is_misaligned(input logic [31:0] addr);
    return (addr & ~ALIGN_MASK) != 32'd0;
  endfunction

endpackage

// File: rtl/pc_next_calc.sv
// Combinational next-PC mux: sequential +4 or redirect target, with limit wrap.
// Misaligned targets trap to TRAP_VEC when PC_MISALIGN_TRAP_EN is defined, else get masked.
module pc_next_calc
  import pc_seq_pkg::*;
#(
  parameter logic [31:0] RESET_VEC = 32'h0000_0000,
  parameter logic [31:0] TRAP_VEC  = 32'h0000_0100
) (
  input  logic        redirect_i,
  input  logic [31:0] target_i,
  input  logic [31:0] pc_i,
  input  logic [31:0] limit_i,
  output logic [31:0] next_pc_o,
  output logic        trap_o
);

`ifdef PC_MISALIGN_TRAP_EN
  localparam bit TrapOn = 1'b1;
`else
  localparam bit TrapOn = 1'b0;
`endif

  logic [31:0] seq_pc;
  logic [31:0] fixed_tgt;
  logic [31:0] redir_pc;

  assign seq_pc = pc_i + WORD_BYTES;
  assign trap_o = TrapOn && redirect_i && is_misaligned(target_i);

  // Alignment is resolved before the limit compare so a masked target is range-checked.
  assign fixed_tgt = trap_o ? TRAP_VEC : (target_i & ALIGN_MASK);
  assign redir_pc  = (fixed_tgt > limit_i) ? RESET_VEC : fixed_tgt;

  assign next_pc_o = redirect_i ? redir_pc
                                : ((seq_pc > limit_i) ? RESET_VEC : seq_pc);

endmodule

// File: rtl/pc_fetch_sequencer.sv
// Front-end fetch controller: owns the PC, runs the imem req/ack handshake and holds words for decode.
// Build option: PC_MISALIGN_TRAP_EN (misaligned redirects pulse o_Trap and go to TRAP_VEC).
module pc_fetch_sequencer
  import pc_seq_pkg::*;
#(
  parameter logic [31:0] RESET_VEC = 32'h0000_0000,
  parameter logic [31:0] PC_LIMIT  = 32'd8188,
  parameter logic [31:0] TRAP_VEC  = 32'h0000_0100
) (
  input  logic        i_Clk,
  input  logic        i_Rst_n,
  input  logic        i_Start,
  input  logic        i_Stall,
  input  logic        i_Redirect,
  input  logic [31:0] iv_Target,
  output logic        o_Imem_Req,
  output logic [31:0] ov_Imem_Addr,
  input  logic        i_Imem_Ack,
  input  logic [31:0] iv_Imem_Data,
  output logic        o_Instr_Valid,
  output logic [31:0] ov_Instr,
  output logic [31:0] ov_Instr_Pc,
  output logic        o_Trap
);

  state_e      state_q, state_d;
  logic [31:0] pc_q, pc_d;
  logic [31:0] pending_q, pending_d;
  logic [31:0] instr_q, instr_d;
  logic [31:0] instr_pc_q, instr_pc_d;
  logic        trap_q, trap_d;
  logic [31:0] calc_pc;
  logic        calc_trap;

  pc_next_calc #(
    .RESET_VEC(RESET_VEC),
    .TRAP_VEC (TRAP_VEC)
  ) u_next_calc (
    .redirect_i(i_Redirect),
    .target_i  (iv_Target),
    .pc_i      (pc_q),
    .limit_i   (PC_LIMIT),
    .next_pc_o (calc_pc),
    .trap_o    (calc_trap)
  );

  always_ff @(posedge i_Clk or negedge i_Rst_n) begin
    if (!i_Rst_n) begin
      state_q    <= ST_IDLE;
      pc_q       <= RESET_VEC;
      pending_q  <= RESET_VEC;
      instr_q    <= 32'd0;
      instr_pc_q <= 32'd0;
      trap_q     <= 1'b0;
    end else begin
      state_q    <= state_d;
      pc_q       <= pc_d;
      pending_q  <= pending_d;
      instr_q    <= instr_d;
      instr_pc_q <= instr_pc_d;
      trap_q     <= trap_d;
    end
  end

  always_comb begin
    state_d    = state_q;
    pc_d       = pc_q;
    pending_d  = pending_q;
    instr_d    = instr_q;
    instr_pc_d = instr_pc_q;
    trap_d     = 1'b0;
    case (state_q)
      ST_IDLE: begin
        if (i_Start) begin
          pc_d    = RESET_VEC;
          state_d = ST_FETCH;
        end
      end
      ST_FETCH: begin
        if (i_Redirect) begin
          trap_d = calc_trap;
          // An in-flight request is never abandoned: park the target until the ack.
          if (i_Imem_Ack) begin
            pc_d = calc_pc;
          end else begin
            pending_d = calc_pc;
            state_d   = ST_DRAIN;
          end
        end else if (i_Imem_Ack) begin
          instr_d    = iv_Imem_Data;
          instr_pc_d = pc_q;
          state_d    = ST_HOLD;
        end
      end
      ST_DRAIN: begin
        if (i_Redirect) begin
          trap_d    = calc_trap;
          pending_d = calc_pc;
        end
        if (i_Imem_Ack) begin
          pc_d    = i_Redirect ? calc_pc : pending_q;
          state_d = ST_FETCH;
        end
      end
      ST_HOLD: begin
        if (i_Redirect) begin
          trap_d  = calc_trap;
          pc_d    = calc_pc;
          state_d = ST_FETCH;
        end else if (!i_Stall) begin
          pc_d    = calc_pc;
          state_d = ST_FETCH;
        end
      end
      default: state_d = ST_IDLE;
    endcase
  end

  assign o_Imem_Req    = (state_q == ST_FETCH) || (state_q == ST_DRAIN);
  assign ov_Imem_Addr  = o_Imem_Req ? pc_q : 32'd0;
  assign o_Instr_Valid = (state_q == ST_HOLD);
  assign ov_Instr      = instr_q;
  assign ov_Instr_Pc   = instr_pc_q;
  assign o_Trap        = trap_q;

endmodule

// File: tb/tb_pc_fetch_sequencer.sv
// Self-checking bench for pc_fetch_sequencer; expected request addresses and decode
// words are queued when stimulus is driven and popped when the DUT presents them.
module tb_pc_fetch_sequencer;

  logic        clk = 1'b0;
  logic        rst_n;
  logic        start;
  logic        stall;
  logic        redirect;
  logic [31:0] target;
  logic        imem_req;
  logic [31:0] imem_addr;
  logic        imem_ack;
  logic [31:0] imem_data;
  logic        instr_valid;
  logic [31:0] instr;
  logic [31:0] instr_pc;
  logic        trap;

  int checks = 0;
  int errors = 0;

  logic [31:0] exp_req_q[$];
  logic [31:0] exp_word_q[$];
  logic [31:0] ea;
  logic [31:0] ew;
  logic [31:0] mis_addr;
  logic        mis_trap;

  always #5 clk = ~clk;

  function automatic logic [31:0] mem_word(input logic [31:0] a);
    return {a[15:0] ^ 16'hC3A5, ~a[15:0]};
  endfunction

  assign imem_data = mem_word(imem_addr);

  pc_fetch_sequencer dut (
    .i_Clk        (clk),
    .i_Rst_n      (rst_n),
    .i_Start      (start),
    .i_Stall      (stall),
    .i_Redirect   (redirect),
    .iv_Target    (target),
    .o_Imem_Req   (imem_req),
    .ov_Imem_Addr (imem_addr),
    .i_Imem_Ack   (imem_ack),
    .iv_Imem_Data (imem_data),
    .o_Instr_Valid(instr_valid),
    .ov_Instr     (instr),
    .ov_Instr_Pc  (instr_pc),
    .o_Trap       (trap)
  );

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic test_reset();
    rst_n = 1'b0; start = 1'b0; stall = 1'b0; redirect = 1'b0; target = 32'd0; imem_ack = 1'b0;
    tick(); tick();
    checks++;
    if (imem_req !== 1'b0 || imem_addr !== 32'd0 || instr_valid !== 1'b0 ||
        instr !== 32'd0 || instr_pc !== 32'd0 || trap !== 1'b0) begin
      errors++;
      $display("FAIL reset_outputs req=%b addr=%h valid=%b instr=%h pc=%h trap=%b required all 0",
               imem_req, imem_addr, instr_valid, instr, instr_pc, trap);
    end
    rst_n = 1'b1;
    for (int i = 0; i < 3; i++) begin
      tick();
      checks++;
      if (imem_req !== 1'b0) begin
        errors++;
        $display("FAIL idle_no_req req=%b required 0", imem_req);
      end
    end
    $display("txn reset done");
  endtask

  task automatic test_sequential();
    imem_ack = 1'b1; stall = 1'b0;
    for (int k = 0; k < 6; k++) begin
      exp_req_q.push_back(32'(k * 4));
      exp_word_q.push_back(32'(k * 4));
    end
    start = 1'b1;
    tick();
    start = 1'b0;
    for (int cyc = 0; cyc < 12; cyc++) begin
      if (cyc % 2 == 0) begin
        ea = exp_req_q.pop_front();
        checks++;
        if (imem_req !== 1'b1 || imem_addr !== ea || instr_valid !== 1'b0) begin
          errors++;
          $display("FAIL seq_req req=%b addr=%h valid=%b required req=1 addr=%h valid=0",
                   imem_req, imem_addr, instr_valid, ea);
        end
        $display("txn req addr=%h", imem_addr);
      end else begin
        ew = exp_word_q.pop_front();
        checks++;
        if (instr_valid !== 1'b1 || instr_pc !== ew || instr !== mem_word(ew) || imem_req !== 1'b0) begin
          errors++;
          $display("FAIL seq_word valid=%b pc=%h instr=%h req=%b required valid=1 pc=%h instr=%h req=0",
                   instr_valid, instr_pc, instr, imem_req, ew, mem_word(ew));
        end
        $display("txn word pc=%h instr=%h", instr_pc, instr);
      end
      if (cyc == 11) stall = 1'b1;
      else tick();
    end
  endtask

  task automatic test_stall();
    for (int i = 0; i < 3; i++) begin
      tick();
      checks++;
      if (instr_valid !== 1'b1 || instr_pc !== 32'd20 || instr !== mem_word(32'd20) || imem_req !== 1'b0) begin
        errors++;
        $display("FAIL stall_hold valid=%b pc=%h instr=%h req=%b required valid=1 pc=%h instr=%h req=0",
                 instr_valid, instr_pc, instr, imem_req, 32'd20, mem_word(32'd20));
      end
    end
    $display("txn stall held 3 cycles");
  endtask

  task automatic test_redirect_drain();
    imem_ack = 1'b0; stall = 1'b0;
    exp_req_q.push_back(32'd24);
    tick();
    ea = exp_req_q.pop_front();
    checks++;
    if (imem_req !== 1'b1 || imem_addr !== ea) begin
      errors++;
      $display("FAIL drain_first_req req=%b addr=%h required req=1 addr=%h", imem_req, imem_addr, ea);
    end
    redirect = 1'b1; target = 32'h40;
    tick();
    redirect = 1'b0;
    for (int i = 0; i < 2; i++) begin
      checks++;
      if (imem_req !== 1'b1 || imem_addr !== ea || instr_valid !== 1'b0) begin
        errors++;
        $display("FAIL drain_hold req=%b addr=%h valid=%b required req=1 addr=%h valid=0",
                 imem_req, imem_addr, instr_valid, ea);
      end
      if (i == 0) tick();
    end
    imem_ack = 1'b1;
    exp_req_q.push_back(32'h40);
    exp_word_q.push_back(32'h40);
    tick();
    ea = exp_req_q.pop_front();
    checks++;
    if (imem_req !== 1'b1 || imem_addr !== ea || instr_valid !== 1'b0) begin
      errors++;
      $display("FAIL drain_next_req req=%b addr=%h valid=%b required req=1 addr=%h valid=0",
               imem_req, imem_addr, instr_valid, ea);
    end
    stall = 1'b1;
    tick();
    ew = exp_word_q.pop_front();
    checks++;
    if (instr_valid !== 1'b1 || instr_pc !== ew || instr !== mem_word(ew)) begin
      errors++;
      $display("FAIL drain_word valid=%b pc=%h instr=%h required valid=1 pc=%h instr=%h",
               instr_valid, instr_pc, instr, ew, mem_word(ew));
    end
    $display("txn redirect via drain pc=%h", instr_pc);
  endtask

  task automatic test_back_to_back();
    stall = 1'b0;
    exp_req_q.push_back(32'h44);
    tick();
    ea = exp_req_q.pop_front();
    checks++;
    if (imem_req !== 1'b1 || imem_addr !== ea) begin
      errors++;
      $display("FAIL b2b_req req=%b addr=%h required req=1 addr=%h", imem_req, imem_addr, ea);
    end
    redirect = 1'b1; target = 32'h80;
    exp_req_q.push_back(32'h80);
    exp_word_q.push_back(32'h80);
    tick();
    redirect = 1'b0; stall = 1'b1;
    ea = exp_req_q.pop_front();
    checks++;
    if (imem_req !== 1'b1 || imem_addr !== ea || instr_valid !== 1'b0) begin
      errors++;
      $display("FAIL b2b_redirect_req req=%b addr=%h valid=%b required req=1 addr=%h valid=0",
               imem_req, imem_addr, instr_valid, ea);
    end
    tick();
    ew = exp_word_q.pop_front();
    checks++;
    if (instr_valid !== 1'b1 || instr_pc !== ew || instr !== mem_word(ew)) begin
      errors++;
      $display("FAIL b2b_word valid=%b pc=%h instr=%h required valid=1 pc=%h", instr_valid, instr_pc, instr, ew);
    end
    $display("txn ack+redirect pc=%h", instr_pc);
  endtask

  task automatic test_wrap();
    logic [31:0] tgts [3];
    logic [31:0] reqs [3];
    tgts[0] = 32'd8188; reqs[0] = 32'd8188;
    tgts[1] = 32'd0;    reqs[1] = 32'd0;
    tgts[2] = 32'h3000; reqs[2] = 32'd0;
    for (int i = 0; i < 3; i++) begin
      exp_req_q.push_back(reqs[i]);
      exp_word_q.push_back(reqs[i]);
      if (i == 1) stall = 1'b0;
      else begin redirect = 1'b1; target = tgts[i]; end
      tick();
      redirect = 1'b0; stall = 1'b1;
      ea = exp_req_q.pop_front();
      checks++;
      if (imem_req !== 1'b1 || imem_addr !== ea) begin
        errors++;
        $display("FAIL wrap_req_%0d req=%b addr=%h required req=1 addr=%h", i, imem_req, imem_addr, ea);
      end
      tick();
      ew = exp_word_q.pop_front();
      checks++;
      if (instr_valid !== 1'b1 || instr_pc !== ew || instr !== mem_word(ew)) begin
        errors++;
        $display("FAIL wrap_word_%0d valid=%b pc=%h required valid=1 pc=%h", i, instr_valid, instr_pc, ew);
      end
      $display("txn wrap step %0d pc=%h", i, instr_pc);
    end
  endtask

  task automatic test_misalign();
`ifdef PC_MISALIGN_TRAP_EN
    mis_addr = 32'h100; mis_trap = 1'b1;
`else
    mis_addr = 32'h40;  mis_trap = 1'b0;
`endif
    redirect = 1'b1; target = 32'h42;
    exp_req_q.push_back(mis_addr);
    exp_word_q.push_back(mis_addr);
    tick();
    redirect = 1'b0;
    ea = exp_req_q.pop_front();
    checks++;
    if (imem_req !== 1'b1 || imem_addr !== ea || trap !== mis_trap) begin
      errors++;
      $display("FAIL misalign_req req=%b addr=%h trap=%b required req=1 addr=%h trap=%b",
               imem_req, imem_addr, trap, ea, mis_trap);
    end
    tick();
    ew = exp_word_q.pop_front();
    checks++;
    if (trap !== 1'b0 || instr_valid !== 1'b1 || instr_pc !== ew) begin
      errors++;
      $display("FAIL misalign_word trap=%b valid=%b pc=%h required trap=0 valid=1 pc=%h",
               trap, instr_valid, instr_pc, ew);
    end
    $display("txn misaligned redirect pc=%h", instr_pc);
  endtask

  task automatic test_reset_mid_drain();
    imem_ack = 1'b0; stall = 1'b0;
    exp_req_q.push_back(mis_addr + 32'd4);
    tick();
    ea = exp_req_q.pop_front();
    checks++;
    if (imem_req !== 1'b1 || imem_addr !== ea) begin
      errors++;
      $display("FAIL rstdrain_req req=%b addr=%h required req=1 addr=%h", imem_req, imem_addr, ea);
    end
    redirect = 1'b1; target = 32'h200;
    tick();
    redirect = 1'b0;
    #2;
    rst_n = 1'b0;
    #1;
    checks++;
    if (imem_req !== 1'b0 || imem_addr !== 32'd0 || instr_valid !== 1'b0 ||
        instr !== 32'd0 || instr_pc !== 32'd0 || trap !== 1'b0) begin
      errors++;
      $display("FAIL async_reset req=%b addr=%h valid=%b instr=%h pc=%h trap=%b required all 0",
               imem_req, imem_addr, instr_valid, instr, instr_pc, trap);
    end
    exp_req_q.delete();
    exp_word_q.delete();
    tick(); tick();
    rst_n = 1'b1;
    for (int i = 0; i < 3; i++) begin
      tick();
      checks++;
      if (imem_req !== 1'b0) begin
        errors++;
        $display("FAIL post_reset_idle req=%b required 0", imem_req);
      end
    end
    imem_ack = 1'b1; stall = 1'b0;
    exp_req_q.push_back(32'd0);
    exp_word_q.push_back(32'd0);
    start = 1'b1;
    tick();
    start = 1'b0;
    ea = exp_req_q.pop_front();
    checks++;
    if (imem_req !== 1'b1 || imem_addr !== ea) begin
      errors++;
      $display("FAIL restart_req req=%b addr=%h required req=1 addr=%h", imem_req, imem_addr, ea);
    end
    stall = 1'b1;
    tick();
    ew = exp_word_q.pop_front();
    checks++;
    if (instr_valid !== 1'b1 || instr_pc !== ew || instr !== mem_word(ew)) begin
      errors++;
      $display("FAIL restart_word valid=%b pc=%h required valid=1 pc=%h", instr_valid, instr_pc, ew);
    end
    $display("txn restart after reset pc=%h", instr_pc);
  endtask

  initial begin
    test_reset();
    test_sequential();
    test_stall();
    test_redirect_drain();
    test_back_to_back();
    test_wrap();
    test_misalign();
    test_reset_mid_drain();
    checks++;
    if (exp_req_q.size() != 0 || exp_word_q.size() != 0) begin
      errors++;
      $display("FAIL scoreboard_empty reqs=%0d words=%0d required 0 0", exp_req_q.size(), exp_word_q.size());
    end
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
